uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- UART bootloader front-end. Receives a framed program image from the host PC over RX and issues word writes into the instruction and data memory programming ports, which are port B of IFetch/DMem.
- Sits directly upstream of the CPU memories and supplies the upg_* signals consumed by IFetch and DMem.
- Sends one-byte status replies on TX.
- Asserts upg_done_o when the host issues the go command; the CPU leaves programming mode on that signal.

Parameters:
- CLKS_PER_BIT, 87: upg_clk_i cycles per UART bit (10 MHz / 115200). Minimum 4.
- TIMEOUT_CYCLES, 10000000: maximum idle cycles between bytes inside a section before the section is aborted.

Ports:
- upg_clk_i  input  1  single clock; all logic is on its rising edge.
- upg_rst_i  input  1  synchronous, active-high reset.
- upg_rx_i  input  1  UART RX, asynchronous, idle high.
- upg_clk_o  output  1  combinational pass-through of upg_clk_i; feeds the memory port-B clock.
- upg_wen_o  output  1  one-cycle word write strobe.
- upg_adr_o  output  15  bit14: 0 = instruction memory, 1 = data memory. Bits[13:0]: word address.
- upg_dat_o  output  32  write data word.
- upg_done_o  output  1  sticky "programming complete" flag.
- upg_tx_o  output  1  UART TX, idle high.

Behaviour:
- Reset (upg_rst_i high at a clock edge): upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_tx_o=1. RX, TX and loader state machines go to IDLE/CMD; the pending reply is cleared. Reset mid-byte or mid-section discards all partial data and issues no write.
- RX path:
  - 2-flop synchronizer on upg_rx_i.
  - Start detect is a high-to-low transition on the synchronized signal. The line is re-sampled at CLKS_PER_BIT/2; if high there, it is a false start and RX returns to idle.
  - 8 data bits are sampled at bit centres, LSB first.
  - Stop bit is sampled at its centre. High: byte_valid pulses for 1 cycle. Low: frame error pulses; the byte is discarded.
- Loader FSM states: CMD, LEN0, LEN1, DATA, GO.
  - CMD:
    - 0x49 ('I'): sel=0, go to LEN0.
    - 0x44 ('D'): sel=1, go to LEN0.
    - 0x47 ('G'): upg_done_o=1 (sticky until reset), reply 0x4B ('K'), stay in CMD.
    - Any other byte: reply 0x3F ('?'), stay in CMD.
  - LEN0/LEN1: capture 16-bit word count N, little-endian. At LEN1:
    - N=0: reply 'K', return to CMD.
    - Otherwise: word address and byte index are cleared, go to DATA.
  - DATA: bytes are assembled little-endian, byte0 into [7:0] through byte3 into [31:24].
    - On the 4th byte, the next cycle has upg_wen_o=1 for exactly 1 cycle, with upg_adr_o={sel, addr} and upg_dat_o=word. These values hold until the next write.
    - addr then increments, wrapping 16383 to 0.
    - After the N-th word: reply 'K', return to CMD.
  - Timeout and frame errors: in LEN0, LEN1 or DATA, an inter-byte idle count reaching TIMEOUT_CYCLES, or any frame error, means reply 0x21 ('!') and return to CMD. The partial word is not written; words already written remain. A frame error in CMD is ignored silently.
  - upg_done_o does not block further commands; sections after 'G' still write.
- TX path:
  - 8N1 transmitter at CLKS_PER_BIT, with a one-entry pending reply register.
  - A reply requested while TX is busy is held in pending. A second request while pending is full overwrites it.
  - Pending data is sent immediately after the current stop bit.

Test Plan:
- Sim with CLKS_PER_BIT=4, TIMEOUT_CYCLES=200.
- Send 49 02 00 | 78 56 34 12 | EF BE AD DE -> two upg_wen_o pulses: adr 0x0000/dat 0x12345678, then adr 0x0001/dat 0xDEADBEEF; TX returns 0x4B; exactly 2 strobes.
- Send 44 01 00 AA BB CC DD then 47 -> one write adr 0x4000/dat 0xDDCCBBAA; TX 0x4B twice; upg_done_o=1 after 'G' stop bit and stays 1.
- Send 5A, then 49 00 00 -> TX 0x3F, then 0x4B; no write strobe.
- Send 49 01 00 11 22, then idle 250 cycles -> TX 0x21, no strobe. A following 47 is accepted, giving TX 0x4B.
- Send 44 01 00 then a byte with stop bit forced low -> TX 0x21, FSM in CMD. A 1.5-cycle low glitch on RX produces no byte.
- Assert upg_rst_i after 2 bytes of a data word -> all outputs at reset values, upg_tx_o=1, no strobe. A new 'I' section starts at address 0.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Memory programming bus driven by the UART loader into port B of IFetch/DMem.
interface uart_prog_loader_if;
  logic        wen;   // one-cycle word write strobe
  logic [14:0] adr;   // [14] memory select (0 = instr, 1 = data), [13:0] word address
  logic [31:0] dat;   // write data word
  logic        done;  // sticky programming-complete flag

  modport master (output wen, adr, dat, done);
  modport slave  (input  wen, adr, dat, done);
endinterface

// File: rtl/uart_prog_loader.sv
// UART bootloader front-end: receives framed program sections over RX, issues
// word writes on the programming bus and returns one-byte status replies on TX.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic               upg_clk_i,
  input  logic               upg_rst_i,
  input  logic               upg_rx_i,
  output logic               upg_clk_o,
  output logic               upg_tx_o,
  uart_prog_loader_if.master upg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_INSTR = 8'h49;  // 'I'
  localparam logic [7:0] CMD_DATA  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] RPL_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_BAD   = 8'h3F;  // '?'
  localparam logic [7:0] RPL_ABORT = 8'h21;  // '!'

  typedef enum logic [2:0] {L_CMD, L_LEN0, L_LEN1, L_DATA, L_GO} ld_state_t;

  assign upg_clk_o = upg_clk_i;

  // ---------------- RX path ----------------
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_busy;
  logic [CNT_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;    // 0 = start check, 1..8 = data, 9 = stop
  logic [7:0]       rx_byte;
  logic             byte_valid, frame_err;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge upg_clk_i) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    if (upg_rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= upg_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: verify start at half bit, shift data LSB first, check stop bit.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_busy    <= 1'b0;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_sync) rx_busy <= 1'b0;   // false start
          else         rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy    <= 1'b0;
          byte_valid <= rx_sync;
          frame_err  <= !rx_sync;
        end else begin
          rx_byte <= {rx_sync, rx_byte[7:1]};
          rx_bit  <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Loader FSM ----------------
  ld_state_t        state, state_next;
  logic             reply_req;
  logic [7:0]       reply_byte;
  logic             sel;
  logic [15:0]      len, word_cnt;
  logic [13:0]      addr;
  logic [1:0]       byte_idx;
  logic [31:0]      word;
  logic [TO_W-1:0]  idle_cnt;
  logic             abort;

  assign abort = frame_err || (idle_cnt == TO_W'(TIMEOUT_CYCLES));

  // Loader state register.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) state <= L_CMD;
    else           state <= state_next;
  end

  // Loader next-state decode and reply requests.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    reply_req  = 1'b0;
    reply_byte = RPL_OK;
    case (state)
      L_CMD: begin
        if (byte_valid) begin
          case (rx_byte)
            CMD_INSTR, CMD_DATA: state_next = L_LEN0;
            CMD_GO:              state_next = L_GO;
            default: begin
              reply_req  = 1'b1;
              reply_byte = RPL_BAD;
            end
          endcase
        end
      end
      L_LEN0, L_LEN1, L_DATA: begin
        if (abort) begin
          reply_req  = 1'b1;
          reply_byte = RPL_ABORT;
          state_next = L_CMD;
        end else if (byte_valid) begin
          if (state == L_LEN0) begin
            state_next = L_LEN1;
          end else if (state == L_LEN1) begin
            if ({rx_byte, len[7:0]} == 16'd0) begin
              reply_req  = 1'b1;
              state_next = L_CMD;
            end else begin
              state_next = L_DATA;
            end
          end else if (byte_idx == 2'd3 && word_cnt == len - 16'd1) begin
            reply_req  = 1'b1;
            state_next = L_CMD;
          end
        end
      end
      L_GO: begin
        reply_req  = 1'b1;
        state_next = L_CMD;
      end
      default: state_next = L_CMD;
    endcase
  end

  // Loader datapath: section header capture, word assembly and write strobe.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      sel      <= 1'b0;
      len      <= '0;
      word_cnt <= '0;
      addr     <= '0;
      byte_idx <= '0;
      word     <= '0;
      idle_cnt <= '0;
      upg.wen  <= 1'b0;
      upg.adr  <= '0;
      upg.dat  <= '0;
      upg.done <= 1'b0;
    end else begin
      upg.wen  <= 1'b0;
      idle_cnt <= (byte_valid || state == L_CMD || state == L_GO) ? '0 : idle_cnt + 1'b1;
      if (state == L_GO) upg.done <= 1'b1;
      if (byte_valid) begin
        case (state)
          L_CMD: begin
            if (rx_byte == CMD_INSTR)     sel <= 1'b0;
            else if (rx_byte == CMD_DATA) sel <= 1'b1;
          end
          L_LEN0: len[7:0] <= rx_byte;
          L_LEN1: begin
            len[15:8] <= rx_byte;
            addr      <= '0;
            byte_idx  <= '0;
            word_cnt  <= '0;
          end
          L_DATA: begin
            word     <= {rx_byte, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              upg.wen  <= 1'b1;
              upg.adr  <= {sel, addr};
              upg.dat  <= {rx_byte, word[31:8]};
              addr     <= addr + 14'd1;
              word_cnt <= word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- TX path ----------------
  logic             tx_busy, pend_valid;
  logic [7:0]       pend_byte;
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic             tx_free, tx_load;

  assign tx_free  = !tx_busy || (tx_cnt == BIT_LAST && tx_bit == 4'd9);
  assign tx_load  = tx_free && (pend_valid || reply_req);
  assign upg_tx_o = tx_shift[0];

  // 8N1 transmitter with a one-entry pending reply that is overwritten when full.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      tx_busy    <= 1'b0;
      tx_shift   <= '1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      pend_valid <= 1'b0;
      pend_byte  <= '0;
    end else begin
      if (reply_req && !(tx_free && !pend_valid)) begin
        pend_valid <= 1'b1;
        pend_byte  <= reply_byte;
      end else if (tx_load) begin
        pend_valid <= 1'b0;
      end
      if (tx_load) begin
        tx_busy  <= 1'b1;
        tx_shift <= {1'b1, (pend_valid ? pend_byte : reply_byte), 1'b0};
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_busy) begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bit   <= tx_bit + 4'd1;
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

endmodule
